layer_compositor: RTL

Parametrised, pipelined pixel compositor for the 65 MHz video path: selects the highest-priority valid layer per pixel among NUM_LAYERS sprite/overlay sources, or the background. Adds frame-synchronous layer enable, 50% translucency against the next layer down, and frame-counted blinking. Sync/blank are delayed to match. Sits between the layer renderers (menu, score, strings, …) and the VGA output register.

---
 rtl/layer_compositor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: priority select, 50% blend, frame-counted blink.
// Latency: 3 clk65 cycles from input sample to pixel/active_layer/sync outputs.
// Backpressure: none; one pixel per cycle, never stalls.
module layer_compositor #(
    parameter int NUM_LAYERS   = 8,
    parameter int COLOR_W      = 12,   // three equal R,G,B channels, so divisible by 3
    parameter int BLINK_FRAMES = 30    // frames per blink half-period, at least 1
) (
    input  logic                                 clk65,
    input  logic                                 reset,
    input  logic [NUM_LAYERS*(COLOR_W+1)-1:0]    layer_pixels,
    input  logic [COLOR_W-1:0]                   bg_pixel,
    input  logic                                 hsync_in,
    input  logic                                 vsync_in,
    input  logic                                 blank_in,
    input  logic                                 frame_start,
    input  logic [NUM_LAYERS-1:0]                enable_mask_in,
    input  logic [NUM_LAYERS-1:0]                blend_mask_in,
    input  logic [NUM_LAYERS-1:0]                blink_mask_in,
    output logic [COLOR_W-1:0]                   pixel,
    output logic                                 hsync_out,
    output logic                                 vsync_out,
    output logic                                 blank_out,
    output logic [$clog2(NUM_LAYERS+1)-1:0]      active_layer,
    output logic                                 blink_phase
);

    localparam int LW    = COLOR_W + 1;
    localparam int CH_W  = COLOR_W / 3;
    localparam int AW    = $clog2(NUM_LAYERS + 1);
    // A one-frame half-period still needs a 1-bit counter.
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Frame-synchronous shadow state
    logic [NUM_LAYERS-1:0] enable_q;
    logic [NUM_LAYERS-1:0] blend_q;
    logic [NUM_LAYERS-1:0] blink_q;
    logic [CNT_W-1:0]      frame_cnt;

    // Unpacked view of the input bus
    logic [NUM_LAYERS-1:0]              in_vld;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] in_col;
    logic [NUM_LAYERS-1:0]              eff_vld;

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]              s1_vld;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] s1_col;
    logic [NUM_LAYERS-1:0]              s1_blend;
    logic [COLOR_W-1:0]                 s1_bg;
    logic                               s1_hs, s1_vs, s1_blank;

    // Stage 2 selection logic and registers
    logic [NUM_LAYERS-1:0]              rest_vld;
    logic [AW-1:0]                      sel_idx;
    logic [COLOR_W-1:0]                 sel_top;
    logic [COLOR_W-1:0]                 sel_under;
    logic                               sel_blend;

    logic [AW-1:0]                      s2_idx;
    logic [COLOR_W-1:0]                 s2_top;
    logic [COLOR_W-1:0]                 s2_under;
    logic                               s2_blend;
    logic                               s2_hs, s2_vs, s2_blank;

    logic [COLOR_W-1:0]                 mix_pix;

    // Per-channel average, rounded down; the extra bit holds the carry.
    function automatic logic [COLOR_W-1:0] blend_avg(input logic [COLOR_W-1:0] a,
                                                     input logic [COLOR_W-1:0] b);
        logic [COLOR_W-1:0] r;
        logic [CH_W:0]      sum;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, a[c*CH_W +: CH_W]} + {1'b0, b[c*CH_W +: CH_W]};
            r[c*CH_W +: CH_W] = sum[CH_W:1];
        end
        return r;
    endfunction

    // Shadow masks and blink counter update only on frame_start
    always_ff @(posedge clk65) begin
        if (reset) begin
            enable_q    <= '1;
            blend_q     <= '0;
            blink_q     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            enable_q <= enable_mask_in;
            blend_q  <= blend_mask_in;
            blink_q  <= blink_mask_in;
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Split the packed bus and apply enable/blink using pre-edge shadow values
    always_comb begin
        in_vld = '0;
        in_col = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            in_vld[i] = layer_pixels[i*LW + COLOR_W];
            in_col[i] = layer_pixels[i*LW +: COLOR_W];
        end
        eff_vld = in_vld & enable_q & ~(blink_q & {NUM_LAYERS{blink_phase}});
    end

    // Stage 1: register inputs together with the blend bits in force for them
    always_ff @(posedge clk65) begin
        if (reset) begin
            s1_vld   <= '0;
            s1_col   <= '0;
            s1_blend <= '0;
            s1_bg    <= '0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_blank <= 1'b0;
        end else begin
            s1_vld   <= eff_vld;
            s1_col   <= in_col;
            s1_blend <= blend_q;
            s1_bg    <= bg_pixel;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_blank <= blank_in;
        end
    end

    // Winner is the lowest valid index; the under layer is the next valid one
    // above it, found by clearing the winner's bit (lowest set bit) first.
    always_comb begin
        sel_idx   = AW'(NUM_LAYERS);
        sel_top   = s1_bg;
        sel_blend = 1'b0;
        sel_under = s1_bg;
        rest_vld  = s1_vld & (s1_vld - NUM_LAYERS'(1));
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_vld[i]) begin
                sel_idx   = AW'(i);
                sel_top   = s1_col[i];
                sel_blend = s1_blend[i];
            end
            if (rest_vld[i]) begin
                sel_under = s1_col[i];
            end
        end
    end

    // Stage 2: register the selection; index resets to background so that
    // active_layer keeps its reset value while the pipe refills.
    always_ff @(posedge clk65) begin
        if (reset) begin
            s2_idx   <= AW'(NUM_LAYERS);
            s2_top   <= '0;
            s2_under <= '0;
            s2_blend <= 1'b0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s2_idx   <= sel_idx;
            s2_top   <= sel_top;
            s2_under <= sel_under;
            s2_blend <= sel_blend;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_blank <= s1_blank;
        end
    end

    // Single-level blend: the under layer's own blend bit plays no part
    always_comb begin
        mix_pix = s2_blend ? blend_avg(s2_top, s2_under) : s2_top;
    end

    // Stage 3: output register, pixel blanked but winner index still reported
    always_ff @(posedge clk65) begin
        if (reset) begin
            pixel        <= '0;
            active_layer <= AW'(NUM_LAYERS);
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            blank_out    <= 1'b0;
        end else begin
            pixel        <= s2_blank ? '0 : mix_pix;
            active_layer <= s2_idx;
            hsync_out    <= s2_hs;
            vsync_out    <= s2_vs;
            blank_out    <= s2_blank;
        end
    end

endmodule
